// File: rtl/cashier_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cashier_pkg
//  Purpose : Shared types, coin encodings and helpers for the coin cashier.
//  Rev     : 1.0  initial release
// ============================================================================
package cashier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_LOAD    = 2'd2,
        ST_REFUND  = 2'd3
    } state_e;

    localparam logic [1:0] c_coin_1   = 2'b00;
    localparam logic [1:0] c_coin_5   = 2'b01;
    localparam logic [1:0] c_coin_10  = 2'b10;
    localparam logic [1:0] c_coin_bad = 2'b11;

    localparam logic [9:0] c_sat_max  = 10'd1023;

    function automatic logic [9:0] coin_value(input logic [1:0] coin_type);
        logic [9:0] v;
        v = 10'd0;
        case (coin_type)
            c_coin_1:  v = 10'd1;
            c_coin_5:  v = 10'd5;
            c_coin_10: v = 10'd10;
            default:   v = 10'd0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coin_cashier_if.sv
`default_nettype none
// ============================================================================
//  Module  : coin_cashier_if
//  Purpose : Player/coin side and game_count side signals of the cashier.
//  Rev     : 1.0  initial release
// ============================================================================
interface coin_cashier_if;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       confirm;
    logic       cancel;
    logic [9:0] remain;
    logic [9:0] money;
    logic       set;
    logic [9:0] credit;
    logic       coin_reject;
    logic       refund_valid;
    logic [9:0] refund_amt;

    modport master (
        output coin_valid, coin_type, confirm, cancel, remain,
        input  money, set, credit, coin_reject, refund_valid, refund_amt
    );

    modport slave (
        input  coin_valid, coin_type, confirm, cancel, remain,
        output money, set, credit, coin_reject, refund_valid, refund_amt
    );
endinterface
`default_nettype wire

// File: rtl/coin_cashier_idle_timer.sv
`default_nettype none
// ============================================================================
//  Module  : idle_timer
//  Purpose : Counts enabled cycles since the last clear; flags the cycle that
//            completes TIMEOUT_CYC of them.
//  Rev     : 1.0  initial release
// ============================================================================
module idle_timer #(
    parameter int TIMEOUT_CYC = 500
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr,
    input  wire logic en,
    output logic      expired
);
    localparam int c_w = $clog2(TIMEOUT_CYC + 1);

    logic [c_w-1:0] r_cnt;

    // expired marks the edge that would complete the final idle cycle
    assign expired = en && !clr && (r_cnt == c_w'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && !expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/coin_cashier.sv
`default_nettype none
// ============================================================================
//  Module  : coin_cashier
//  Purpose : Coin collection, buy/cancel/timeout handling and saturating load
//            of credit into the downstream game_count stage.
//  Rev     : 1.0  initial release
// ============================================================================
module coin_cashier
    import cashier_pkg::*;
#(
    parameter int MAX_CREDIT  = 999,
    parameter int MIN_BUY     = 5,
    parameter int TIMEOUT_CYC = 500
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    coin_cashier_if.slave  bus
);
    localparam logic [1:0] c_st_idle    = ST_IDLE;
    localparam logic [1:0] c_st_collect = ST_COLLECT;
    localparam logic [1:0] c_st_load    = ST_LOAD;
    localparam logic [1:0] c_st_refund  = ST_REFUND;

    logic [1:0]  r_state;
    logic [9:0]  r_credit;
    logic [9:0]  r_money;
    logic        r_set;
    logic        r_coin_reject;
    logic        r_refund_valid;
    logic [9:0]  r_refund_amt;

    logic [9:0]  w_coin_val;
    logic        w_coin_ok;
    logic [10:0] w_sum_credit;
    logic        w_fits;
    logic        w_in_collect;
    logic        w_cancel;
    logic        w_buy;
    logic        w_accept;
    logic [10:0] w_load_sum;
    logic        w_over;
    logic [9:0]  w_excess;
    logic        w_timer_clr;
    logic        w_expired;

    assign w_coin_val   = coin_value(bus.coin_type);
    assign w_coin_ok    = bus.coin_valid && (bus.coin_type != c_coin_bad);
    assign w_sum_credit = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_fits       = (w_sum_credit <= 11'(MAX_CREDIT));
    assign w_in_collect = (r_state == c_st_collect);
    assign w_cancel     = w_in_collect && bus.cancel;
    assign w_buy        = w_in_collect && !bus.cancel && bus.confirm
                          && (r_credit >= 10'(MIN_BUY));
    assign w_accept     = w_coin_ok && ((r_state == c_st_idle)
                          || (w_in_collect && !w_cancel && !w_buy && w_fits));

    assign w_load_sum   = {1'b0, bus.remain} + {1'b0, r_credit};
    assign w_over       = (w_load_sum > {1'b0, c_sat_max});
    // Overflowed sums lie in 1024..2022, so the low 10 bits minus 1023 is the exact excess
    assign w_excess     = w_load_sum[9:0] - c_sat_max;

    assign w_timer_clr  = !w_in_collect || w_accept;

    idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_timer_clr),
        .en      (w_in_collect),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_st_idle;
            r_credit       <= '0;
            r_money        <= '0;
            r_set          <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_refund_valid <= 1'b0;
            r_refund_amt   <= '0;
        end else begin
            r_set          <= 1'b0;
            r_refund_valid <= 1'b0;
            r_refund_amt   <= '0;
            r_coin_reject  <= bus.coin_valid && !w_accept;

            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_credit <= w_coin_val;
                        r_state  <= c_st_collect;
                    end
                end
                c_st_collect: begin
                    if (w_cancel || (!w_buy && w_expired)) begin
                        r_state        <= c_st_refund;
                        r_refund_valid <= 1'b1;
                        r_refund_amt   <= r_credit;
                    end else if (w_buy) begin
                        r_state        <= c_st_load;
                        r_set          <= 1'b1;
                        r_money        <= w_over ? c_sat_max : w_load_sum[9:0];
                        r_refund_valid <= w_over;
                        r_refund_amt   <= w_over ? w_excess : 10'd0;
                    end else if (w_accept) begin
                        r_credit <= w_sum_credit[9:0];
                    end
                end
                c_st_load, c_st_refund: begin
                    r_credit <= '0;
                    r_state  <= c_st_idle;
                end
                default: begin
                    r_credit <= '0;
                    r_state  <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.money        = r_money;
    assign bus.set          = r_set;
    assign bus.credit       = r_credit;
    assign bus.coin_reject  = r_coin_reject;
    assign bus.refund_valid = r_refund_valid;
    assign bus.refund_amt   = r_refund_amt;
endmodule
`default_nettype wire
